// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the decompressor SRAM port arbiter.
// Holds the arbiter FSM encoding, requester indices and round-robin helpers.
package sram_port_arbiter_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;
   localparam int NUM_REQ     = 3;

   localparam int REQ_DECODE = 0;
   localparam int REQ_IDCT   = 1;
   localparam int REQ_UCSC   = 2;

   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_GRANTED    = 2'd1,
      ARB_TURNAROUND = 2'd2
   } arb_state_e;

   // First set request at or after ptr, scanning upward and wrapping; one-hot result.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [1:0]         ptr);
      logic [NUM_REQ-1:0] win;
      win = 3'b000;
      case (ptr)
         2'd0: win = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
         2'd1: win = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
         2'd2: win = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
         default: win = 3'b000;
      endcase
      return win;
   endfunction

   function automatic logic [1:0] rr_next_ptr(input logic [NUM_REQ-1:0] win);
      logic [1:0] nxt;
      nxt = 2'd0;
      case (win)
         3'b001:  nxt = 2'd1;
         3'b010:  nxt = 2'd2;
         3'b100:  nxt = 2'd0;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// READ_LATENCY-deep shift register of per-requester read tags.
// The last stage lines up with SRAM read data returning to the owner.
module sram_rd_tag_pipe
   import sram_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] tag_i,
   output logic [NUM_REQ-1:0] tag_o
);

   logic [NUM_REQ-1:0] stage_q [DEPTH];

   // Shift tags one stage per cycle; reset discards everything in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= 3'b000;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin request/grant arbiter for the shared external SRAM port.
// Grants are registered; the SRAM side mirrors the current owner.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int MAX_HOLD     = 256
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*SRAM_ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*SRAM_DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]             req_we_n,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             rd_valid,
   output logic                           revoked,
   output logic [SRAM_ADDR_W-1:0]         SRAM_address,
   output logic [SRAM_DATA_W-1:0]         SRAM_write_data,
   output logic                           SRAM_we_n
);

   localparam logic [9:0] HOLD_SAT  = 10'd1023;
   localparam logic [9:0] HOLD_LAST = 10'(MAX_HOLD - 1);
   localparam bit         REVOKE_EN = (MAX_HOLD != 0);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [9:0]         hold_q, hold_d;
   logic               revoked_q, revoked_d;
   logic               owner_req_s, other_req_s;
   logic [NUM_REQ-1:0] read_tag_s;

   assign owner_req_s = |(req & grant_q);
   assign other_req_s = |(req & ~grant_q);

   // Next-state logic; release takes priority over forced revoke.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      revoked_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            hold_d = 10'd0;
            if (|req) begin
               grant_d = rr_pick(req, ptr_q);
               ptr_d   = rr_next_ptr(grant_d);
               state_d = ARB_GRANTED;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANTED: begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 10'd1;
            if (!owner_req_s) begin
               grant_d = 3'b000;
               state_d = ARB_TURNAROUND;
            end else if (REVOKE_EN && (hold_q == HOLD_LAST) && other_req_s) begin
               grant_d   = 3'b000;
               revoked_d = 1'b1;
               state_d   = ARB_TURNAROUND;
            end else begin
               state_d = ARB_GRANTED;
            end
         end
         ARB_TURNAROUND: begin
            hold_d  = 10'd0;
            state_d = ARB_IDLE;
         end
         default: begin
            grant_d = 3'b000;
            hold_d  = 10'd0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= ARB_IDLE;
         grant_q   <= 3'b000;
         ptr_q     <= 2'd0;
         hold_q    <= 10'd0;
         revoked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         revoked_q <= revoked_d;
      end
   end

   // SRAM side follows the owner; with no owner it idles as a read of address 0.
   always_comb begin
      SRAM_address    = 18'd0;
      SRAM_write_data = 16'd0;
      SRAM_we_n       = 1'b1;
      case (grant_q)
         3'b001: begin
            SRAM_address    = req_addr[REQ_DECODE*SRAM_ADDR_W +: SRAM_ADDR_W];
            SRAM_write_data = req_wdata[REQ_DECODE*SRAM_DATA_W +: SRAM_DATA_W];
            SRAM_we_n       = req_we_n[REQ_DECODE];
         end
         3'b010: begin
            SRAM_address    = req_addr[REQ_IDCT*SRAM_ADDR_W +: SRAM_ADDR_W];
            SRAM_write_data = req_wdata[REQ_IDCT*SRAM_DATA_W +: SRAM_DATA_W];
            SRAM_we_n       = req_we_n[REQ_IDCT];
         end
         3'b100: begin
            SRAM_address    = req_addr[REQ_UCSC*SRAM_ADDR_W +: SRAM_ADDR_W];
            SRAM_write_data = req_wdata[REQ_UCSC*SRAM_DATA_W +: SRAM_DATA_W];
            SRAM_we_n       = req_we_n[REQ_UCSC];
         end
         default: begin
            SRAM_address    = 18'd0;
            SRAM_write_data = 16'd0;
            SRAM_we_n       = 1'b1;
         end
      endcase
   end

   assign read_tag_s = grant_q & {NUM_REQ{SRAM_we_n}};

   sram_rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rd_tag_pipe (
      .clk_i (Clock),
      .rst_i (Reset),
      .tag_i (read_tag_s),
      .tag_o (rd_valid)
   );

   assign grant   = grant_q;
   assign revoked = revoked_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a cycle-level tenure model.
// Model tracks owner, granted-cycle count, quiet cycles and a read-tag history.
module tb_sram_port_arbiter;

   localparam int RL = 2;
   localparam int MH = 4;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [2:0]  req;
   logic [53:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  req_we_n;
   logic [2:0]  grant;
   logic [2:0]  rd_valid;
   logic        revoked;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   int n_cmp = 0;
   int n_err = 0;

   int         m_owner;
   int         m_held;
   int         m_ptr;
   int         m_quiet;
   bit         m_rev;
   logic [2:0] m_hist[$];
   bit         did_midreset = 1'b0;

   sram_port_arbiter #(.READ_LATENCY(RL), .MAX_HOLD(MH)) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .req             (req),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_we_n        (req_we_n),
      .grant           (grant),
      .rd_valid        (rd_valid),
      .revoked         (revoked),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_quiet = 0;
      m_rev   = 1'b0;
      m_hist.delete();
      for (int i = 0; i < RL; i++) m_hist.push_back(3'b000);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_grant"}, 32'(grant), 32'd0);
      check_eq({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
      check_eq({tag, "_addr"}, 32'(SRAM_address), 32'd0);
      check_eq({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
      check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check_eq({tag, "_revoked"}, 32'(revoked), 32'd0);
   endtask

   // Compare this cycle's outputs, then advance the model across the next edge.
   task automatic step();
      logic [2:0]  exp_grant;
      logic [17:0] exp_addr;
      logic [15:0] exp_wd;
      logic        exp_we;
      logic [2:0]  tag;
      exp_grant = 3'b000;
      exp_addr  = 18'd0;
      exp_wd    = 16'd0;
      exp_we    = 1'b1;
      if (m_owner >= 0) begin
         exp_grant = 3'b001 << m_owner;
         exp_addr  = req_addr[m_owner*18 +: 18];
         exp_wd    = req_wdata[m_owner*16 +: 16];
         exp_we    = req_we_n[m_owner];
      end
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("sram_addr", 32'(SRAM_address), 32'(exp_addr));
      check_eq("sram_wdata", 32'(SRAM_write_data), 32'(exp_wd));
      check_eq("sram_we_n", 32'(SRAM_we_n), 32'(exp_we));
      check_eq("rd_valid", 32'(rd_valid), 32'(m_hist[0]));
      check_eq("revoked", 32'(revoked), 32'(m_rev));

      tag = (m_owner >= 0 && exp_we) ? exp_grant : 3'b000;
      void'(m_hist.pop_front());
      m_hist.push_back(tag);
      m_rev = 1'b0;
      if (m_owner >= 0) begin
         m_held++;
         if (!req[m_owner]) begin
            m_owner = -1;
            m_quiet = 1;
         end else if (m_held == MH && (req & ~exp_grant) != 3'b000) begin
            m_owner = -1;
            m_quiet = 1;
            m_rev   = 1'b1;
         end
      end else if (m_quiet != 0) begin
         m_quiet = 0;
      end else if (req != 3'b000) begin
         for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (req[c]) begin
               m_owner = c;
               m_held  = 0;
               m_ptr   = (c + 1) % 3;
               break;
            end
         end
      end
   endtask

   task automatic randomize_payload();
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_we_n  = 3'($urandom);
   endtask

   initial begin
      Reset     = 1'b1;
      req       = 3'b000;
      req_addr  = 54'd0;
      req_wdata = 48'd0;
      req_we_n  = 3'b111;
      model_reset();
      repeat (2) @(negedge Clock);
      #1;
      check_reset_outputs("por");
      Reset = 1'b0;

      // Single decode read at 0x10: grant next cycle, strobe RL cycles later.
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         req      = (i < 4) ? 3'b001 : 3'b000;
         req_addr = {36'd0, 18'h00010};
         req_we_n = 3'b111;
         #1;
         step();
      end

      // All three requesting: rotation plus forced revokes.
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         req = 3'b111;
         randomize_payload();
         #1;
         step();
      end

      // Sticky random requests, with one async reset during an IDCT tenure.
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clock);
         if (!did_midreset && i > 200 && m_owner == 1) begin
            did_midreset = 1'b1;
            Reset = 1'b1;
            #1;
            check_reset_outputs("midreset");
            @(negedge Clock);
            #1;
            check_reset_outputs("midreset_hold");
            Reset = 1'b0;
            model_reset();
            step();
         end else begin
            for (int b = 0; b < 3; b++)
               if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            randomize_payload();
            #1;
            step();
         end
      end
      check_eq("midreset_done", 32'(did_midreset), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
